// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, button codes, FSM states.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [2:0] BTN_NONE    = 3'b000;
  localparam logic [2:0] BTN_LOAD_A  = 3'b100;
  localparam logic [2:0] BTN_LOAD_B  = 3'b010;
  localparam logic [2:0] BTN_LOAD_OP = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_OP,
    S_SETTLE,
    S_CAPTURE
  } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Expected ALU result for the opcodes the sequencer knows how to check.
// Only instantiated when ALU_SEQ_CHECK_EN is defined.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_op,
  output logic [DATA_WIDTH-1:0] o_expected,
  output logic                  o_modelled
);

  always_comb begin
    o_expected = '0;
    o_modelled = 1'b1;
    case (i_op)
      DATA_WIDTH'(OP_ADD): o_expected = i_a + i_b;
      DATA_WIDTH'(OP_SUB): o_expected = i_a - i_b;
      DATA_WIDTH'(OP_AND): o_expected = i_a & i_b;
      DATA_WIDTH'(OP_OR):  o_expected = i_a | i_b;
      DATA_WIDTH'(OP_XOR): o_expected = i_a ^ i_b;
      DATA_WIDTH'(OP_NOR): o_expected = ~(i_a | i_b);
      DATA_WIDTH'(OP_SRA): o_expected = DATA_WIDTH'($signed(i_a) >>> i_b);
      DATA_WIDTH'(OP_SRL): o_expected = i_a >> i_b;
      default:             o_modelled = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives an ALU top through A/B/OP button loads, waits, then captures its LED result.
// Optional result checking against alu_ref_model is enabled by defining ALU_SEQ_CHECK_EN.
//
// state     | meaning
// S_IDLE    | ready for a command
// S_LOAD_A  | switches = A, load-A button
// S_LOAD_B  | switches = B, load-B button
// S_LOAD_OP | switches = OP, load-OP button
// S_SETTLE  | buttons released, ALU result settling
// S_CAPTURE | LED bus sampled at end of this cycle
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 6,
  parameter int BTN_WIDTH     = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic [DATA_WIDTH-1:0] i_op,
  output logic [DATA_WIDTH-1:0] o_sw,
  output logic [BTN_WIDTH-1:0]  o_buttons,
  input  logic [DATA_WIDTH-1:0] i_led,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_result_valid,
  output logic                  o_mismatch
);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_settle_cnt, w_settle_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_op;
  logic [DATA_WIDTH-1:0] r_sw, w_sw_nxt;
  logic [BTN_WIDTH-1:0]  r_buttons, w_buttons_nxt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_result_valid;
  logic                  w_accept;
  logic                  w_capture;

  // Switch/button values are computed for the state being entered so the pins are registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_sw_nxt         = r_sw;
    w_buttons_nxt    = BTN_WIDTH'(BTN_NONE);
    w_accept         = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_accept      = 1'b1;
          w_state_nxt   = S_LOAD_A;
          w_sw_nxt      = i_data_a;
          w_buttons_nxt = BTN_WIDTH'(BTN_LOAD_A);
        end
      end
      S_LOAD_A: begin
        w_state_nxt   = S_LOAD_B;
        w_sw_nxt      = r_b;
        w_buttons_nxt = BTN_WIDTH'(BTN_LOAD_B);
      end
      S_LOAD_B: begin
        w_state_nxt   = S_LOAD_OP;
        w_sw_nxt      = r_op;
        w_buttons_nxt = BTN_WIDTH'(BTN_LOAD_OP);
      end
      S_LOAD_OP: begin
        w_state_nxt      = S_SETTLE;
        w_sw_nxt         = r_op;
        w_settle_cnt_nxt = 4'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        if (r_settle_cnt == 4'd0) w_state_nxt = S_CAPTURE;
        else                      w_settle_cnt_nxt = r_settle_cnt - 4'd1;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_settle_cnt   <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_sw           <= '0;
      r_buttons      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_settle_cnt   <= w_settle_cnt_nxt;
      r_sw           <= w_sw_nxt;
      r_buttons      <= w_buttons_nxt;
      r_result_valid <= w_capture;
      if (w_accept) begin
        r_a  <= i_data_a;
        r_b  <= i_data_b;
        r_op <= i_op;
      end
      if (w_capture) r_result <= i_led;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [DATA_WIDTH-1:0] w_expected;
  logic                  w_modelled;
  logic                  r_mismatch;

  alu_ref_model #(.DATA_WIDTH(DATA_WIDTH)) u_ref_model (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_op       (r_op),
    .o_expected (w_expected),
    .o_modelled (w_modelled)
  );

  // Unmodelled opcodes clear the flag rather than leave a stale result.
  always_ff @(posedge clock) begin
    if (reset)          r_mismatch <= 1'b0;
    else if (w_capture) r_mismatch <= w_modelled && (i_led != w_expected);
  end

  assign o_mismatch = r_mismatch;
`else
  assign o_mismatch = 1'b0;
`endif

  assign o_ready        = (r_state == S_IDLE);
  assign o_sw           = r_sw;
  assign o_buttons      = r_buttons;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU top plus expected-sequence model, two settle depths.
module tb_alu_cmd_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 1;
`ifdef ALU_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [5:0] data_a = '0, data_b = '0, data_op = '0;

  logic       ready0, rv0, mm0, ready1, rv1, mm1;
  logic [5:0] sw0, result0, led0, sw1, result1, led1;
  logic [2:0] btn0, btn1;

  logic [5:0] alu0_a = '0, alu0_b = '0, alu0_op = '0;
  logic [5:0] alu1_a = '0, alu1_b = '0, alu1_op = '0;
  logic       force_en = 1'b0;
  logic [5:0] force_val = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] prev_result0 = '0;

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_fn(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 6'($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return a ^ ~b;
    endcase
  endfunction

  function automatic bit is_modelled(input logic [5:0] op);
    return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b100110, 6'b100111, 6'b000011, 6'b000010};
  endfunction

  // Behavioural ALU top: latches the switch bus on each load button.
  always @(posedge clk) begin
    if (btn0[2]) alu0_a  <= sw0;
    if (btn0[1]) alu0_b  <= sw0;
    if (btn0[0]) alu0_op <= sw0;
    if (btn1[2]) alu1_a  <= sw1;
    if (btn1[1]) alu1_b  <= sw1;
    if (btn1[0]) alu1_op <= sw1;
  end
  assign led0 = force_en ? force_val : alu_fn(alu0_a, alu0_b, alu0_op);
  assign led1 = alu_fn(alu1_a, alu1_b, alu1_op);

  alu_cmd_sequencer #(.DATA_WIDTH(6), .BTN_WIDTH(3), .SETTLE_CYCLES(S0)) dut0 (
    .clock(clk), .reset(reset), .i_valid(i_valid), .o_ready(ready0),
    .i_data_a(data_a), .i_data_b(data_b), .i_op(data_op),
    .o_sw(sw0), .o_buttons(btn0), .i_led(led0),
    .o_result(result0), .o_result_valid(rv0), .o_mismatch(mm0)
  );

  alu_cmd_sequencer #(.DATA_WIDTH(6), .BTN_WIDTH(3), .SETTLE_CYCLES(S1)) dut1 (
    .clock(clk), .reset(reset), .i_valid(i_valid), .o_ready(ready1),
    .i_data_a(data_a), .i_data_b(data_b), .i_op(data_op),
    .o_sw(sw1), .o_buttons(btn1), .i_led(led1),
    .o_result(result1), .o_result_valid(rv1), .o_mismatch(mm1)
  );

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if ($countones(btn0) > 1 || $countones(btn1) > 1) begin
        n_err++;
        $display("FAIL onehot: btn0=%b btn1=%b, want at most one bit set", btn0, btn1);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!(ready0 && ready1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!(ready0 && ready1)) begin
      n_err++;
      $display("FAIL wait_ready: ready0=%b ready1=%b, want 1 1", ready0, ready1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_valid = 1'b1;
    data_a = 6'h15; data_b = 6'h0A; data_op = 6'b100000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ready0 !== 1'b1)   begin n_err++; $display("FAIL reset_ready: got %b want 1", ready0); end
    n_cmp++; if (btn0 !== 3'b000)   begin n_err++; $display("FAIL reset_btn: got %b want 000", btn0); end
    n_cmp++; if (sw0 !== 6'd0)      begin n_err++; $display("FAIL reset_sw: got %b want 0", sw0); end
    n_cmp++; if (result0 !== 6'd0)  begin n_err++; $display("FAIL reset_result: got %b want 0", result0); end
    n_cmp++; if (rv0 !== 1'b0)      begin n_err++; $display("FAIL reset_valid: got %b want 0", rv0); end
    n_cmp++; if (mm0 !== 1'b0)      begin n_err++; $display("FAIL reset_mismatch: got %b want 0", mm0); end
    reset = 1'b0;
    i_valid = 1'b0;
    prev_result0 = '0;
  endtask

  task automatic run_cmd(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op,
                         input bit fe, input logic [5:0] fv);
    logic [5:0] exp_res, exp_btn, exp_sw, exp_now;
    bit exp_v, exp_mm;
    wait_ready();
    force_en = fe;
    force_val = fv;
    data_a = a; data_b = b; data_op = op;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    data_a = 6'($urandom); data_b = 6'($urandom); data_op = 6'($urandom);
    exp_res = fe ? fv : alu_fn(a, b, op);
    exp_mm  = CHK && is_modelled(op) && (exp_res != alu_fn(a, b, op));
    for (int k = 0; k <= 4 + S0; k++) begin
      if (k > 0) @(negedge clk);
      exp_btn = (k == 0) ? 6'b100 : (k == 1) ? 6'b010 : (k == 2) ? 6'b001 : 6'b000;
      exp_sw  = (k == 0) ? a : (k == 1) ? b : op;
      exp_v   = (k == 4 + S0);
      exp_now = exp_v ? exp_res : prev_result0;
      n_cmp++;
      if ({3'b000, btn0} !== exp_btn) begin
        n_err++; $display("FAIL cmd_btn k=%0d: got %b want %b", k, btn0, exp_btn[2:0]);
      end
      if (k <= 3 + S0) begin
        n_cmp++;
        if (sw0 !== exp_sw) begin n_err++; $display("FAIL cmd_sw k=%0d: got %b want %b", k, sw0, exp_sw); end
      end
      n_cmp++;
      if (rv0 !== exp_v) begin n_err++; $display("FAIL cmd_valid k=%0d: got %b want %b", k, rv0, exp_v); end
      n_cmp++;
      if (ready0 !== exp_v) begin n_err++; $display("FAIL cmd_ready k=%0d: got %b want %b", k, ready0, exp_v); end
      n_cmp++;
      if (result0 !== exp_now) begin n_err++; $display("FAIL cmd_result k=%0d: got %b want %b", k, result0, exp_now); end
    end
    n_cmp++;
    if (mm0 !== exp_mm) begin n_err++; $display("FAIL cmd_mismatch op=%b: got %b want %b", op, mm0, exp_mm); end
    prev_result0 = exp_res;
    @(negedge clk);
    n_cmp++;
    if (rv0 !== 1'b0) begin n_err++; $display("FAIL cmd_pulse_width: got %b want 0", rv0); end
    force_en = 1'b0;
  endtask

  task automatic test_directed();
    run_cmd(6'b000011, 6'b000101, 6'b100000, 1'b0, 6'd0);
    run_cmd(6'b000111, 6'b000010, 6'b100010, 1'b0, 6'd0);
    run_cmd(6'b000011, 6'b000101, 6'b100000, 1'b1, 6'b000111);
    run_cmd(6'b000011, 6'b000011, 6'b100100, 1'b0, 6'd0);
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b100111, 6'b000011, 6'b000010};
    logic [5:0] op;
    int sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 8) ? ops[sel] : 6'($urandom);
      run_cmd(6'($urandom), 6'($urandom), op, ($urandom_range(0, 3) == 0), 6'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    int p1 = -1, p2 = -1, ready_between = 0;
    wait_ready();
    data_a = 6'b000011; data_b = 6'b000011; data_op = 6'b100100;
    i_valid = 1'b1;
    for (int t = 0; t < 40 && p2 < 0; t++) begin
      @(negedge clk);
      if (rv0) begin
        n_cmp++;
        if (result0 !== 6'b000011) begin n_err++; $display("FAIL b2b_result: got %b want 000011", result0); end
        if (p1 < 0) p1 = t; else p2 = t;
      end else if (p1 >= 0 && ready0) begin
        ready_between++;
      end
    end
    i_valid = 1'b0;
    n_cmp++;
    if (p2 - p1 !== 5 + S0 || p1 < 0) begin
      n_err++; $display("FAIL b2b_spacing: got p1=%0d p2=%0d want spacing %0d", p1, p2, 5 + S0);
    end
    n_cmp++;
    if (ready_between !== 0) begin n_err++; $display("FAIL b2b_ready_low: got %0d ready cycles want 0", ready_between); end
    prev_result0 = 6'b000011;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    wait_ready();
    data_a = 6'h2A; data_b = 6'h11; data_op = 6'b100101;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (btn0 !== 3'b010) begin n_err++; $display("FAIL rstmid_in_load_b: got %b want 010", btn0); end
    reset = 1'b1;
    i_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (btn0 !== 3'b000)  begin n_err++; $display("FAIL rstmid_btn: got %b want 000", btn0); end
    n_cmp++; if (sw0 !== 6'd0)     begin n_err++; $display("FAIL rstmid_sw: got %b want 0", sw0); end
    n_cmp++; if (ready0 !== 1'b1)  begin n_err++; $display("FAIL rstmid_ready: got %b want 1", ready0); end
    reset = 1'b0;
    i_valid = 1'b0;
    prev_result0 = '0;
    for (int t = 0; t < 12; t++) begin
      if (rv0) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_settle1();
    int lat = -1;
    logic [5:0] a, b, res;
    a = 6'($urandom); b = 6'($urandom);
    wait_ready();
    data_a = a; data_b = b; data_op = 6'b100110;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (rv1 && lat < 0) begin lat = k; res = result1; end
    end
    n_cmp++;
    if (lat !== 4 + S1) begin n_err++; $display("FAIL settle1_latency: got %0d want %0d", lat, 4 + S1); end
    n_cmp++;
    if (lat >= 0 && res !== (a ^ b)) begin n_err++; $display("FAIL settle1_result: got %b want %b", res, a ^ b); end
    n_cmp++;
    if (mm1 !== 1'b0) begin n_err++; $display("FAIL settle1_mismatch: got %b want 0", mm1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_settle1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
